fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the fetch stage: owns the PC register and selects the next fetch address.
//  Sources, by priority: reset vector, branch redirect, interrupt entry, two-word
//  (instruction+immediate) fetch, sequential increment.
//  Sits between the instruction memory address port and the hazard/branch/interrupt logic.
//  Makes instruction+immediate fetch atomic w.r.t. interrupts.
//  Drains in-flight instructions before vectoring to the interrupt handler.
// PARAMETERS
//  ADDR_W       32      PC width
//  PC_INC       1       increment per 16-bit word (instruction memory is word addressed)
//  RESET_VEC    32'h20  PC loaded while rst
//  INT_VEC      32'h0   interrupt handler entry
//  DRAIN_CYCLES 3       non-stalled cycles to wait after taking an interrupt (4'd1..15)
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       synchronous, active-high reset
//  stall        in   1       hold PC and state; drain counter frozen
//  jumpBit      in   1       branch/jump resolved taken this cycle
//  branchIR     in   ADDR_W  redirect target, valid with jumpBit
//  interruptReq in   1       level/pulse interrupt request
//  hasImmediate in   1       word currently fetched is an instruction carrying an immediate
//  pc           out  ADDR_W  current fetch address (registered)
//  fetchValid   out  1       word at pc is to be latched into IF/ID
//  fetchIsImm   out  1       word at pc is an immediate, not an opcode
//  flush        out  1       kill younger in-flight words (combinational, 1 cycle)
//  intAck       out  1       1-cycle pulse: handler vectoring done
//  savedPc      out  ADDR_W  return address for the handler (registered)
// BEHAVIOUR
//  States: FETCH, IMM, DRAIN. Encoding: 2 bits, FETCH=0.
//  rst (any state, wins over all):
//   - pc<=RESET_VEC, state<=FETCH, savedPc<=0, intPending<=0, drainCnt<=0.
//   - All 1-bit outputs are 0 in the rst cycle.
//   - First valid fetch is in the cycle after rst falls.
//  intPending: sticky.
//   - Set on interruptReq.
//   - Cleared only in the cycle intAck=1; a request arriving in that same cycle keeps it set.
//  FETCH (fetchValid=!stall):
//   - stall: hold everything.
//   - jumpBit: pc<=branchIR, flush=1, stay FETCH.
//   - intPending: fetchValid=0, savedPc<=pc, flush=1, drainCnt<=DRAIN_CYCLES, ->DRAIN.
//   - hasImmediate: pc<=pc+PC_INC, ->IMM.
//   - otherwise: pc<=pc+PC_INC.
//  IMM (fetchValid=!stall, fetchIsImm=1):
//   - stall: hold.
//   - jumpBit: pc<=branchIR, flush=1, ->FETCH.
//   - else pc<=pc+PC_INC, ->FETCH.
//   - Interrupts are never taken in IMM.
//  DRAIN (fetchValid=0, pc held):
//   - jumpBit from an older instruction: savedPc<=branchIR, flush=1. The interrupt return
//     address follows the branch.
//   - !stall: drainCnt-1.
//   - At drainCnt==1 & !stall: pc<=INT_VEC, intAck=1, ->FETCH.
//   - jumpBit and the final drain cycle coincide: both apply.
//  Priority in FETCH/IMM: rst > stall > jumpBit > interrupt > immediate > increment.
//  A stall in the same cycle as jumpBit holds the PC; the jump is not captured.
//  Arithmetic: pc+PC_INC is modulo 2^ADDR_W. 32'hFFFF_FFFF wraps to 0 with no flag.
//  Latency: redirect/increment visible on pc one cycle after the deciding edge.
//  Interrupt entry latency: 1 + DRAIN_CYCLES + number of stall cycles.
// STRUCTURE
//  Shared header FetchDefs.vh:
//   - State codes FETCH/IMM/DRAIN.
//   - RESET_VEC and INT_VEC defaults.
//   - PC_INC.
//  Sub-module int_request_latch:
//   - The sticky intPending flop with set/clear/rst priority.
//  The rest is one always block for the registers plus one combinational next-state/next-pc block.
// TESTING
//  1. rst for 2 cycles, then release:
//     pc=0x20, fetchValid=1; next cycles pc=0x21, 0x22.
//  2. At pc=0x30, hasImmediate=1:
//     next cycle pc=0x31 with fetchIsImm=1; then pc=0x32, fetchIsImm=0.
//  3. jumpBit=1, branchIR=0x100 in FETCH and again in IMM:
//     flush=1 that cycle, pc=0x100 next; from IMM the state returns to FETCH.
//  4. interruptReq at pc=0x40 in FETCH, DRAIN_CYCLES=3, no stall:
//     savedPc=0x40, 3 cycles fetchValid=0, then intAck=1, pc=0x0.
//     Repeat with interruptReq while in IMM: taken one cycle later, savedPc=next opcode address.
//  5. During DRAIN, jumpBit with branchIR=0x80:
//     savedPc=0x80, flush=1. Add 2 stall cycles: intAck is delayed by exactly 2.
//  6. Edge cases:
//     - pc=0xFFFF_FFFF increments to 0.
//     - rst asserted mid-DRAIN gives pc=0x20, intPending=0, no intAck.
//     - interruptReq coincident with intAck causes a second DRAIN entry.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: state codes and parameter defaults.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        IMM   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int          ADDR_W_DEF    = 32;
    localparam logic [31:0] PC_INC_DEF    = 32'd1;
    localparam logic [31:0] RESET_VEC_DEF = 32'h20;
    localparam logic [31:0] INT_VEC_DEF   = 32'h0;
    localparam logic [3:0]  DRAIN_DEF     = 4'd3;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/redirect inputs and fetch outputs of the fetch sequencer.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              stall;
    logic              jump_bit;
    logic [ADDR_W-1:0] branch_ir;
    logic              interrupt_req;
    logic              has_immediate;
    logic [ADDR_W-1:0] pc;
    logic              fetch_valid;
    logic              fetch_is_imm;
    logic              flush;
    logic              int_ack;
    logic [ADDR_W-1:0] saved_pc;

    modport master (
        input  stall, jump_bit, branch_ir, interrupt_req, has_immediate,
        output pc, fetch_valid, fetch_is_imm, flush, int_ack, saved_pc
    );

    modport slave (
        output stall, jump_bit, branch_ir, interrupt_req, has_immediate,
        input  pc, fetch_valid, fetch_is_imm, flush, int_ack, saved_pc
    );
endinterface

// File: rtl/fetch_sequencer_int_request_latch.sv
// Sticky interrupt request flop; a new request beats the acknowledge clear.
module fetch_sequencer_int_request_latch (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic pending
);

    logic q;

    always_ff @(posedge clk) begin
        if (rst)
            q <= 1'b0;
        else if (set)
            q <= 1'b1;
        else if (clr)
            q <= 1'b0;
    end

    // A request seen this cycle can be taken immediately.
    assign pending = q | set;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC owner: reset, redirect, interrupt entry with drain, imm fetch.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W       = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] PC_INC       = ADDR_W'(PC_INC_DEF),
    parameter logic [ADDR_W-1:0] RESET_VEC    = ADDR_W'(RESET_VEC_DEF),
    parameter logic [ADDR_W-1:0] INT_VEC      = ADDR_W'(INT_VEC_DEF),
    parameter logic [3:0]        DRAIN_CYCLES = DRAIN_DEF
) (
    input logic               clk,
    input logic               rst,
    fetch_sequencer_if.master bus
);

    state_t            state, state_n;
    logic [ADDR_W-1:0] pc_q, pc_n;
    logic [ADDR_W-1:0] saved_q, saved_n;
    logic [3:0]        cnt_q, cnt_n;
    logic              pending;
    logic              fetch_valid, fetch_is_imm, flush, ack;

    fetch_sequencer_int_request_latch u_int_latch (
        .clk     (clk),
        .rst     (rst),
        .set     (bus.interrupt_req),
        .clr     (ack),
        .pending (pending)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            pc_q    <= RESET_VEC;
            saved_q <= '0;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            saved_q <= saved_n;
            cnt_q   <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        saved_n = saved_q;
        cnt_n   = cnt_q;
        if (!bus.stall) begin
            unique case (state)
                FETCH: begin
                    if (bus.jump_bit) begin
                        pc_n = bus.branch_ir;
                    end else if (pending) begin
                        saved_n = pc_q;
                        cnt_n   = DRAIN_CYCLES;
                        state_n = DRAIN;
                    end else begin
                        pc_n = pc_q + PC_INC;
                        if (bus.has_immediate)
                            state_n = IMM;
                    end
                end
                IMM: begin
                    pc_n    = bus.jump_bit ? bus.branch_ir : pc_q + PC_INC;
                    state_n = FETCH;
                end
                DRAIN: begin
                    // An older branch resolving now moves the return address.
                    if (bus.jump_bit)
                        saved_n = bus.branch_ir;
                    cnt_n = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pc_n    = INT_VEC;
                        state_n = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    always_comb begin
        fetch_valid  = 1'b0;
        fetch_is_imm = 1'b0;
        flush        = 1'b0;
        ack          = 1'b0;
        if (!rst) begin
            unique case (state)
                FETCH: begin
                    fetch_valid = !bus.stall && (bus.jump_bit || !pending);
                    flush       = !bus.stall && (bus.jump_bit || pending);
                end
                IMM: begin
                    fetch_valid  = !bus.stall;
                    fetch_is_imm = 1'b1;
                    flush        = !bus.stall && bus.jump_bit;
                end
                DRAIN: begin
                    flush = !bus.stall && bus.jump_bit;
                    ack   = !bus.stall && (cnt_q == 4'd1);
                end
                default: ;
            endcase
        end
    end

    assign bus.pc           = pc_q;
    assign bus.saved_pc     = saved_q;
    assign bus.fetch_valid  = fetch_valid;
    assign bus.fetch_is_imm = fetch_is_imm;
    assign bus.flush        = flush;
    assign bus.int_ack      = ack;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scoreboard bench for fetch_sequencer.
module tb_fetch_sequencer;

    typedef struct {
        int          step;
        logic [31:0] pc;
        logic        fv;
        logic        imm;
        logic        fl;
        logic        ack;
        logic [31:0] sv;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   fails;
    int   step;
    exp_t sb[$];

    fetch_sequencer_if #(.ADDR_W(32)) bus();

    fetch_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic cyc(
        input logic r, input logic s, input logic j,
        input logic [31:0] br, input logic q, input logic h,
        input logic [31:0] epc, input logic efv, input logic eimm,
        input logic efl, input logic eack, input logic [31:0] esv
    );
        exp_t e;
        @(posedge clk);
        #1;
        step++;
        rst               = r;
        bus.stall         = s;
        bus.jump_bit      = j;
        bus.branch_ir     = br;
        bus.interrupt_req = q;
        bus.has_immediate = h;
        sb.push_back('{step, epc, efv, eimm, efl, eack, esv});
        #1;
        e = sb.pop_front();
        chk($sformatf("s%0d.pc", e.step), bus.pc, e.pc);
        chk($sformatf("s%0d.fetch_valid", e.step), 32'(bus.fetch_valid), 32'(e.fv));
        chk($sformatf("s%0d.fetch_is_imm", e.step), 32'(bus.fetch_is_imm), 32'(e.imm));
        chk($sformatf("s%0d.flush", e.step), 32'(bus.flush), 32'(e.fl));
        chk($sformatf("s%0d.int_ack", e.step), 32'(bus.int_ack), 32'(e.ack));
        chk($sformatf("s%0d.saved_pc", e.step), bus.saved_pc, e.sv);
    endtask

    initial begin
        total = 0;
        fails = 0;
        step  = 0;
        rst   = 1'b1;
        bus.stall         = 1'b0;
        bus.jump_bit      = 1'b0;
        bus.branch_ir     = '0;
        bus.interrupt_req = 1'b0;
        bus.has_immediate = 1'b0;

        // reset and sequential fetch
        cyc(1,0,0,32'h0,0,0, 32'h20,0,0,0,0,32'h0);
        cyc(1,0,0,32'h0,0,0, 32'h20,0,0,0,0,32'h0);
        cyc(0,0,0,32'h0,0,0, 32'h20,1,0,0,0,32'h0);
        cyc(0,0,0,32'h0,0,0, 32'h21,1,0,0,0,32'h0);
        cyc(0,0,0,32'h0,0,0, 32'h22,1,0,0,0,32'h0);
        cyc(0,0,1,32'h30,0,0, 32'h23,1,0,1,0,32'h0);
        // instruction + immediate
        cyc(0,0,0,32'h0,0,1, 32'h30,1,0,0,0,32'h0);
        cyc(0,0,0,32'h0,0,0, 32'h31,1,1,0,0,32'h0);
        cyc(0,0,0,32'h0,0,0, 32'h32,1,0,0,0,32'h0);
        // jumps from FETCH and IMM
        cyc(0,0,1,32'h100,0,0, 32'h33,1,0,1,0,32'h0);
        cyc(0,0,0,32'h0,0,1, 32'h100,1,0,0,0,32'h0);
        cyc(0,0,1,32'h100,0,0, 32'h101,1,1,1,0,32'h0);
        cyc(0,0,1,32'h40,0,0, 32'h100,1,0,1,0,32'h0);
        // interrupt from FETCH
        cyc(0,0,0,32'h0,1,0, 32'h40,0,0,1,0,32'h0);
        cyc(0,0,0,32'h0,0,0, 32'h40,0,0,0,0,32'h40);
        cyc(0,0,0,32'h0,0,0, 32'h40,0,0,0,0,32'h40);
        cyc(0,0,0,32'h0,0,0, 32'h40,0,0,0,1,32'h40);
        // interrupt raised in IMM, taken at next opcode
        cyc(0,0,0,32'h0,0,1, 32'h0,1,0,0,0,32'h40);
        cyc(0,0,0,32'h0,1,0, 32'h1,1,1,0,0,32'h40);
        cyc(0,0,0,32'h0,0,0, 32'h2,0,0,1,0,32'h40);
        // branch during drain, then two stalls
        cyc(0,0,1,32'h80,0,0, 32'h2,0,0,1,0,32'h2);
        cyc(0,1,0,32'h0,0,0, 32'h2,0,0,0,0,32'h80);
        cyc(0,1,0,32'h0,0,0, 32'h2,0,0,0,0,32'h80);
        cyc(0,0,0,32'h0,0,0, 32'h2,0,0,0,0,32'h80);
        cyc(0,0,0,32'h0,0,0, 32'h2,0,0,0,1,32'h80);
        // pc wrap
        cyc(0,0,1,32'hFFFF_FFFF,0,0, 32'h0,1,0,1,0,32'h80);
        cyc(0,0,0,32'h0,0,0, 32'hFFFF_FFFF,1,0,0,0,32'h80);
        cyc(0,0,0,32'h0,0,0, 32'h0,1,0,0,0,32'h80);
        // reset in the middle of a drain
        cyc(0,0,0,32'h0,1,0, 32'h1,0,0,1,0,32'h80);
        cyc(1,0,0,32'h0,0,0, 32'h1,0,0,0,0,32'h1);
        cyc(0,0,0,32'h0,0,0, 32'h20,1,0,0,0,32'h0);
        // request coincident with ack re-enters drain
        cyc(0,0,0,32'h0,1,0, 32'h21,0,0,1,0,32'h0);
        cyc(0,0,0,32'h0,0,0, 32'h21,0,0,0,0,32'h21);
        cyc(0,0,0,32'h0,0,0, 32'h21,0,0,0,0,32'h21);
        cyc(0,0,0,32'h0,1,0, 32'h21,0,0,0,1,32'h21);
        cyc(0,0,0,32'h0,0,0, 32'h0,0,0,1,0,32'h21);
        cyc(0,0,0,32'h0,0,0, 32'h0,0,0,0,0,32'h0);
        cyc(0,0,0,32'h0,0,0, 32'h0,0,0,0,0,32'h0);
        cyc(0,0,0,32'h0,0,0, 32'h0,0,0,0,1,32'h0);
        // stall with jump holds the pc
        cyc(0,1,1,32'h55,0,0, 32'h0,0,0,0,0,32'h0);
        cyc(0,0,0,32'h0,0,0, 32'h0,1,0,0,0,32'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
